// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes, ALU operation classes and ALU control codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RD1   = 2'b10;

  localparam logic [1:0] SRC_B_RD2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields onto the
// datapath ALU control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only means subtract for register-register ops, not addi
          3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for a multicycle RISC-V datapath: sequences fetch,
// decode and per-class execute states and drives the datapath selects.
module mc_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_w,
  output logic       reg_w,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal
);

  state_e     state_q, state_d;
  state_e     out_state;
  logic [1:0] aluop;
  logic       pc_update;
  logic       branch;

  always_ff @(posedge clk) begin
    if (srst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // During reset the outputs present FETCH values, with enables masked below
  assign out_state = srst ? S_FETCH : state_q;

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RD2;
    aluop      = ALUOP_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (out_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURES;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_w      = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_w      = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RD1;
        aluop     = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_w      = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRC_A_RD1;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_update = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
    if (srst) begin
      ir_write   = 1'b0;
      mem_w      = 1'b0;
      reg_w      = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign pc_write = ~srst & (pc_update | (branch & zero));

  always_comb begin
    case (op)
      OP_LW, OP_ITYPE: imm_src = IMM_I;
      OP_SW:           imm_src = IMM_S;
      OP_BEQ:          imm_src = IMM_B;
      OP_JAL:          imm_src = IMM_J;
      default:         imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Randomized instruction-level bench for mc_controller: each instruction class
// has a per-cycle table of expected control outputs.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       srst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, ir_write, mem_w, reg_w;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       instr_done, illegal;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

  int         checkCount = 0;
  int         errorCount = 0;
  logic [6:0] illOp;
  logic [17:0] obs;

  mc_controller dut (
    .clk         (clk),
    .srst        (srst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .mem_w       (mem_w),
    .reg_w       (reg_w),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, adr_src, ir_write, mem_w, reg_w, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, instr_done, illegal};

  task automatic checkOutput(input string tag, input logic [17:0] got, input logic [17:0] want);
    checkCount++;
    if (got !== want) begin
      errorCount++;
      $display("[TB] FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  function automatic logic [17:0] pack(input logic pcw, input logic adr, input logic irw,
                                       input logic memw, input logic regw, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic done, input logic ill);
    return {pcw, adr, irw, memw, regw, res, a, b, imm, alu, done, ill};
  endfunction

  function automatic logic [6:0] opOf(input int kind);
    case (kind)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_JAL:   return 7'b1101111;
      K_BEQ:   return 7'b1100011;
      default: return illOp;
    endcase
  endfunction

  function automatic int lenOf(input int kind);
    case (kind)
      K_LW:    return 5;
      K_BEQ:   return 3;
      K_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic isLegal(input logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
           (o == 7'b0010011) || (o == 7'b1101111) || (o == 7'b1100011);
  endfunction

  function automatic logic [6:0] randIllegal();
    logic [6:0] v;
    do v = 7'($urandom_range(0, 127)); while (isLegal(v));
    return v;
  endfunction

  function automatic logic [1:0] immOf(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // Arithmetic op chosen by funct3; only register-register ops honour the subtract bit
  function automatic logic [2:0] aluOf(input int kind, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (kind == K_R && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [17:0] resetVec(input logic [6:0] o);
    return pack(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, immOf(o), 3'b000, 0, 0);
  endfunction

  function automatic logic [17:0] expected(input int kind, input int step, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7, input logic z);
    logic [1:0] imm;
    imm = immOf(o);
    if (step == 0) return pack(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
    if (step == 1) return pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, kind == K_ILL);
    if (step == 2) begin
      case (kind)
        K_LW, K_SW: return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0, 0);
        K_R:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, aluOf(kind, f3, f7), 0, 0);
        K_I:   return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, aluOf(kind, f3, f7), 0, 0);
        K_JAL: return pack(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 0, 0);
        default: return pack(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 3'b001, 1, 0);
      endcase
    end
    if (step == 3) begin
      case (kind)
        K_LW:    return pack(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0, 0);
        K_SW:    return pack(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
        default: return pack(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
      endcase
    end
    return pack(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1, 0);
  endfunction

  // Runs one instruction from FETCH; rstStep >= 0 raises srst in that cycle and abandons it
  task automatic applyStimulus(input int kind, input logic [2:0] f3, input logic f7,
                               input int zsel, input int rstStep);
    logic [6:0] o;
    o = opOf(kind);
    for (int s = 0; s < lenOf(kind); s++) begin
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      zero     = (kind == K_BEQ && s == 2 && zsel >= 0) ? (zsel != 0) : 1'($urandom_range(0, 1));
      if (s == rstStep) begin
        srst = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("reset kind%0d step%0d", kind, s), obs, resetVec(o));
        @(posedge clk);
        #1;
        srst = 1'b0;
        return;
      end
      @(negedge clk);
      checkOutput($sformatf("kind%0d op%b step%0d f3=%0d f7=%0b z=%0b", kind, o, s, f3, f7, zero),
                  obs, expected(kind, s, o, f3, f7, zero));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int kind;
    int rs;
    srst     = 1'b1;
    op       = 7'd0;
    funct3   = 3'd0;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    illOp    = 7'h7F;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      op   = 7'($urandom_range(0, 127));
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput($sformatf("in reset cycle%0d", i), obs, resetVec(op));
      @(posedge clk);
      #1;
    end
    srst = 1'b0;

    applyStimulus(K_LW,  3'd0, 1'b0, -1, -1);
    applyStimulus(K_SW,  3'd2, 1'b1, -1, -1);
    applyStimulus(K_R,   3'd0, 1'b1, -1, -1);
    applyStimulus(K_R,   3'd0, 1'b0, -1, -1);
    applyStimulus(K_I,   3'd0, 1'b1, -1, -1);
    applyStimulus(K_BEQ, 3'd0, 1'b0,  1, -1);
    applyStimulus(K_BEQ, 3'd0, 1'b0,  0, -1);
    illOp = 7'b1111111;
    applyStimulus(K_ILL, 3'd0, 1'b0, -1, -1);
    applyStimulus(K_LW,  3'd0, 1'b0, -1,  3);
    applyStimulus(K_JAL, 3'd5, 1'b1, -1, -1);

    for (int n = 0; n < 120; n++) begin
      kind  = $urandom_range(0, 6);
      illOp = randIllegal();
      rs    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lenOf(kind) - 1) : -1;
      applyStimulus(kind, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port `clk`, reset port `srst`.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- srst  in  1  synchronous active-high reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0=PC, 1=ALU result register
- ir_write  out  1  instruction register load enable
- mem_w  out  1  data memory write enable
- reg_w  out  1  register file write enable
- result_src  out  2  result mux select: 00=ALUOut, 01=read data, 10=ALU result
- alu_src_a  out  2  ALU A select: 00=PC, 01=old PC, 10=RD1
- alu_src_b  out  2  ALU B select: 00=RD2, 01=imm_ext, 10=constant 4
- imm_src  out  2  extend-unit format select
- alu_control  out  3  ALU operation code
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode

Function
REQ-003 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-004 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR for lw (0000011) or sw (0100011); ->EXECR for R (0110011); ->EXECI for I-ALU (0010011); ->BEQ for beq (1100011); ->JAL for jal (1101111); any other opcode->FETCH with illegal=1.
- MEMADR->MEMREAD if op=lw, else ->MEMWRITE.
- MEMREAD->MEMWB.
- EXECR, EXECI, JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-005 Per-state outputs (listed signals only; all others 0):
- FETCH: adr_src=0, ir_write=1, a=00, b=10, aluop=00, result_src=10, pc_update=1.
- DECODE: a=01, b=01, aluop=00.
- MEMADR: a=10, b=01, aluop=00.
- MEMREAD: adr_src=1, result_src=00.
- MEMWB: result_src=01, reg_w=1.
- MEMWRITE: adr_src=1, mem_w=1.
- EXECR: a=10, b=00, aluop=10.
- EXECI: a=10, b=01, aluop=10.
- ALUWB: result_src=00, reg_w=1.
- BEQ: a=10, b=00, aluop=01, result_src=00, branch=1.
- JAL: a=01, b=10, aluop=00, result_src=00, pc_update=1.
REQ-006 pc_write SHALL equal pc_update OR (branch AND zero), combinationally from the current-cycle `zero`.
REQ-007 imm_src SHALL decode combinationally from op in every state: lw/I-ALU=00, sw=01, beq=10, jal=11, otherwise 00.
REQ-008 alu_control:
- aluop 00 -> 000 (add).
- aluop 01 -> 001 (sub).
- aluop 10 -> by funct3: 000 -> 001 if (op[5] AND funct7b5) else 000; 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); other funct3 -> 000.
REQ-009 Latency SHALL be, in cycles counted from FETCH: lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3, illegal opcode 2.
REQ-010 instr_done SHALL be 1 exactly in MEMWB, MEMWRITE, ALUWB and BEQ.
REQ-011 op/funct inputs are sampled every cycle and SHALL NOT be latched internally; the datapath IR holds them stable from DECODE onward.

Reset
REQ-012 srst high at a clock edge SHALL set the state to FETCH, overriding any transition, including mid-instruction.
REQ-013 While srst is high, pc_write, ir_write, reg_w, mem_w, instr_done and illegal SHALL be forced to 0; all other outputs SHALL show FETCH values.
REQ-014 The first FETCH with full enables SHALL be the first cycle after srst deasserts.

Structure
REQ-015 Package `riscv_ctrl_pkg` SHALL hold the state enum, the opcode constants, the aluop encoding and the alu_control encodings.
REQ-016 ALU decoding (REQ-008) SHALL be a sub-module `alu_decoder` (inputs aluop, funct3, op[5], funct7b5); state register and output decode SHALL live in mc_controller.

Verification
REQ-017 lw (op=0000011) after reset: states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_w=1 and result_src=01 only in cycle 5; instr_done pulses in cycle 5.
REQ-018 sw (op=0100011): mem_w=1 and adr_src=1 only in cycle 4; reg_w never 1; imm_src=01 throughout.
REQ-019 R-type, funct3=000, funct7b5=1: alu_control=001 in EXECR; same with funct7b5=0 -> 000; I-ALU (op=0010011), funct3=000, funct7b5=1 -> 000.
REQ-020 beq with zero=1 in the BEQ cycle -> pc_write=1 there; with zero=0 -> pc_write=0; both return to FETCH next cycle.
REQ-021 op=1111111 -> illegal=1 in DECODE, FETCH next cycle, no reg_w/mem_w asserted.
REQ-022 srst asserted during MEMREAD -> FETCH next cycle, reg_w never asserted for that lw, write enables 0 while srst=1.
